// File: rtl/uart_fifo_xcvr.sv
// Buffered UART transceiver: TX/RX circular FIFOs around 16x-oversampled TX and RX engines.
// Define UART_PARITY_EN to add an even parity bit (XOR of the data bits) to every frame.
module uart_fifo_xcvr #(
    parameter int unsigned BAUD_DIV   = 325,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              uart_tx,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic              tx_busy,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_rd,
    output logic              rx_empty,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    // Shared baud tick generator
    logic [BW-1:0] baud_q;
    logic          tick;

    assign tick = (baud_q == BW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) baud_q <= '0;
        else        baud_q <= tick ? '0 : baud_q + 1'b1;
    end

    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // TX FIFO
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wptr_q, tx_rptr_q;
    logic [AW:0]       tx_cnt_q;
    logic              tx_push, tx_pop, tx_fifo_empty;

    assign tx_fifo_empty = (tx_cnt_q == '0);
    assign tx_full       = (tx_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign tx_push       = tx_wr && !tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // TX engine; every state change happens on a tick so each bit lasts exactly 16 ticks
    state_e            tx_state_q, tx_state_d;
    logic [4:0]        tx_tcnt_q, tx_tcnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_load;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 5'd1;
            unique case (tx_state_q)
                StIdle: begin
                    tx_tcnt_d = '0;
                    tx_load   = !tx_fifo_empty;
                end
                StStart: begin
                    if (tx_tcnt_q == 5'd15) begin
                        tx_tcnt_d  = '0;
                        tx_bit_d   = '0;
                        tx_line_d  = tx_shift_q[0];
                        tx_state_d = StData;
                    end
                end
                StData: begin
                    if (tx_tcnt_q == 5'd15) begin
                        tx_tcnt_d = '0;
                        if (tx_bit_q == 4'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                            tx_line_d  = tx_par_q;
                            tx_state_d = StPar;
`else
                            tx_line_d  = 1'b1;
                            tx_state_d = StStop;
`endif
                        end else begin
                            tx_bit_d   = tx_bit_q + 4'd1;
                            tx_shift_d = tx_shift_q >> 1;
                            tx_line_d  = tx_shift_q[1];
                        end
                    end
                end
                StPar: begin
                    if (tx_tcnt_q == 5'd15) begin
                        tx_tcnt_d  = '0;
                        tx_line_d  = 1'b1;
                        tx_state_d = StStop;
                    end
                end
                StStop: begin
                    if (tx_tcnt_q == 5'(STOP_BITS * 16 - 1)) begin
                        tx_tcnt_d  = '0;
                        tx_state_d = StIdle;
                        tx_load    = !tx_fifo_empty;
                    end
                end
                default: tx_state_d = StIdle;
            endcase
        end
        // Loading straight out of STOP gives back-to-back frames with no idle gap
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rptr_q];
            tx_line_d  = 1'b0;
            tx_tcnt_d  = '0;
            tx_state_d = StStart;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_mem[tx_rptr_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= StIdle;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign uart_tx = tx_line_q;
    assign tx_busy = !tx_fifo_empty || (tx_state_q != StIdle);

    // RX FIFO
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wptr_q, rx_rptr_q;
    logic [AW:0]       rx_cnt_q;
    logic              rx_push, rx_pop, rx_full;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign rx_pop   = rx_rd && !rx_empty;
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rptr_q];
    assign irq      = !rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // RX engine; samples land mid-bit because START re-samples 8 ticks after the falling edge
    state_e     rx_state_q, rx_state_d;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
`ifdef UART_PARITY_EN
    logic       rx_par_q, rx_par_d;
    logic       parity_err_q, parity_err_d;
`endif

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tcnt_d   = rx_tcnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d     = rx_par_q;
        parity_err_d = 1'b0;
`endif
        unique case (rx_state_q)
            StIdle: begin
                rx_tcnt_d = '0;
                if (!rx_sync_q) rx_state_d = StStart;
            end
            StStart: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? StIdle : StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_tcnt_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                        rx_bit_d   = rx_bit_q + 4'd1;
                        if (rx_bit_q == 4'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state_d = StPar;
`else
                            rx_state_d = StStop;
`endif
                        end
                    end
                end
            end
            StPar: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_tcnt_d  = '0;
                        rx_state_d = StStop;
`ifdef UART_PARITY_EN
                        rx_par_d   = rx_sync_q;
`endif
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_tcnt_d  = '0;
                        rx_state_d = StIdle;
                        if (!rx_sync_q) begin
                            frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
                        end else if (rx_par_q != ^rx_shift_q) begin
                            parity_err_d = 1'b1;
`endif
                        end else if (rx_full) begin
                            overrun_d = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q  <= StIdle;
            rx_tcnt_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q  <= rx_state_d;
            rx_tcnt_q   <= rx_tcnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
            rx_par_q     <= rx_par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_fifo_xcvr.md
# uart_fifo_xcvr

Parametrised, buffered UART transceiver for the CPU's peripheral bus, replacing the fixed 8N1 unbuffered UART. It sits beside the peripheral block. The CPU writes transmit words into a TX FIFO and reads received words from an RX FIFO. Error and interrupt flags are available for the IRQ line. Data width, stop bits, FIFO depth and baud divisor are parameters; parity is a compile-time option.

## Interface
- BAUD_DIV, default 325: clk cycles per 16x oversample tick (50 MHz / 9600 / 16); must be ≥2.
- DATA_W, default 8: data bits per frame, legal range 5..8.
- STOP_BITS, default 1: stop bits transmitted, 1 or 2; the receiver always checks only the first.
- FIFO_DEPTH, default 4: entries per FIFO; must be a power of two, ≥2.
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, asynchronous to clk.
- uart_tx  out  1  serial output.
- tx_data  in  DATA_W  word to transmit.
- tx_wr  in  1  push tx_data into the TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FIFO not empty, or frame in progress.
- rx_data  out  DATA_W  head of the RX FIFO (first-word fall-through).
- rx_rd  in  1  pop the RX FIFO.
- rx_empty  out  1  RX FIFO empty.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 without UART_PARITY_EN.
- overrun  out  1  one-cycle pulse: received word dropped because the RX FIFO was full.
- irq  out  1  equals ~rx_empty.

## Operation
- Baud tick generator:
  - Free-running counter, 0..BAUD_DIV-1.
  - Pulses `tick` for one clk when it wraps.
  - One bit period is 16 ticks.
  - TX and RX share the tick generator; RX keeps its own 0..15 sub-counter.
- Input synchroniser: uart_rx passes through a 2-flop synchroniser, reset value 1.
- RX FSM, states IDLE, START, DATA, PAR, STOP:
  - IDLE → START on synchronised rx = 0.
  - START: after 8 ticks, re-sample the line. If it is high, treat it as a glitch and return to IDLE. If low, go to DATA.
  - DATA: sample every 16 ticks, LSB first, DATA_W bits.
  - PAR: present only with UART_PARITY_EN.
  - STOP: one sample.
    - Stop = 1, FIFO not full: push the word.
    - Stop = 1, FIFO full: pulse overrun and discard the word.
    - Stop = 0: pulse frame_err and discard the word; no push.
  - STOP → IDLE in all cases.
- TX FSM, states IDLE, START, DATA, PAR, STOP:
  - IDLE: when the TX FIFO is non-empty, pop one word into the shift register on a tick boundary.
  - START: drive 0 for 16 ticks.
  - DATA: DATA_W bits, LSB first, 16 ticks each.
  - PAR: present only with UART_PARITY_EN.
  - STOP: drive 1 for STOP_BITS×16 ticks, then return to IDLE.
  - Back-to-back words produce no idle gap.
- FIFOs:
  - Circular buffer with read/write pointers and a count of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
  - tx_wr while tx_full: ignored, no state change.
  - rx_rd while rx_empty: ignored.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - A push while full is never accepted, even if a pop occurs in the same cycle.
  - An RX push and an rx_rd in the same cycle when the FIFO is full: the pop is performed and the incoming word is discarded with overrun.
- Reset values:
  - uart_tx = 1, tx_full = 0, tx_busy = 0, rx_empty = 1, irq = 0.
  - All error pulses = 0, rx_data = 0.
  - Both FSMs in IDLE; FIFOs empty.
  - Reset mid-frame aborts the frame immediately; uart_tx returns high asynchronously.

## Timing
- All outputs are registered except rx_data, which is a combinational read of the FIFO head.
- tx_wr at edge N: tx_full and tx_busy update at N+1.
- TX start bit begins within 1 tick plus 1 clk of the FIFO going non-empty while TX is idle.
- RX word is visible (rx_empty = 0) 1 clk after the stop-bit sample tick.
- RX stop sample point is mid-bit, 8 ticks into the stop bit.
- rx_rd at edge N: rx_data shows the next entry and rx_empty updates at N+1.
- Frame length: (1 + DATA_W + P + STOP_BITS) × 16 × BAUD_DIV clk, where P = 1 with parity and 0 without.

## Configuration
- UART_PARITY_EN defined:
  - Parity bit inserted after the data bits; even parity, i.e. XOR of the data bits.
  - RX checks the parity bit; on mismatch it pulses parity_err and discards the word.
  - If stop is also low, frame_err has priority and parity_err does not pulse.
- UART_PARITY_EN undefined:
  - No parity bit; parity_err tied 0.

## Test plan
- Single TX, BAUD_DIV=4, DATA_W=8, no parity, tx_data=8'hA5:
  - uart_tx shows 0, 1,0,1,0,0,1,0,1, 1, each bit 64 clk.
  - tx_busy falls after 640 clk.
- Loopback, uart_tx tied to uart_rx; write 8'h00, 8'hFF, 8'h3C, 8'hC3:
  - The same four words are read back in order.
  - irq is high while any word is unread.
  - No error pulses.
- Fill TX, FIFO_DEPTH=4; write 6 words back-to-back:
  - tx_full asserts after the 4th accepted write.
  - The 5th write, issued before any pop, is ignored.
  - Exactly the accepted words appear on uart_tx.
- RX overrun; send 5 frames with no rx_rd:
  - overrun pulses once, on the 5th stop sample.
  - The FIFO holds the first 4 words.
- Errors:
  - 4-clk low glitch on uart_rx: no reception.
  - Frame with stop bit 0: frame_err pulses, rx_empty stays 1.
  - With UART_PARITY_EN, flipped parity on 8'h01: parity_err pulses.
- Assert reset mid-TX frame:
  - uart_tx = 1, tx_busy = 0, rx_empty = 1 immediately.
  - After release, a fresh write transmits normally.
